// File: rtl/race_pkg.sv
// Shared race definitions: game state encoding, car operation codes, widths.
// Imported by the race sequencer and the physics engine.
package race_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    SETTING   = 3'd1,
    COUNTDOWN = 3'd3,
    RACING    = 3'd4,
    PAUSE     = 3'd5,
    FINISH    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    NIL      = 3'd0,
    FORWARD  = 3'd1,
    BACKWARD = 3'd2,
    LEFT     = 3'd3,
    RIGHT    = 3'd4
  } op_e;

endpackage

// File: rtl/race_controller_if.sv
// Button/finish-line pulses into the race sequencer and its registered status out.
// master drives the pulses, slave is the sequencer.
interface race_controller_if;
  import race_pkg::*;

  logic               start_p;
  logic               confirm_p;
  logic               pause_p;
  logic               lap_cross_p;
  logic [STATE_W-1:0] state;
  logic [2:0]         countdown;
  logic [3:0]         lap_count;
  logic [9:0]         race_time;
  logic               phys_tick;
  logic               finish_p;

  modport master (
    output start_p, confirm_p, pause_p, lap_cross_p,
    input  state, countdown, lap_count, race_time, phys_tick, finish_p
  );

  modport slave (
    input  start_p, confirm_p, pause_p, lap_cross_p,
    output state, countdown, lap_count, race_time, phys_tick, finish_p
  );

endinterface

// File: rtl/race_controller_tick_divider.sv
// Free-running modulo-DIV prescaler with enable (hold when low) and clear.
// tick is combinational: high during the enabled cycle whose edge wraps the count.
module tick_divider #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Kept independent of clr so the owner may clear on the very tick it reacts to.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/race_controller.sv
// Race sequencer: IDLE/SETTING/COUNTDOWN/RACING/PAUSE/FINISH, lap counter, race timer, physics strobe.
// All outputs registered; a state change appears one cycle after the causing pulse.
module race_controller
  import race_pkg::*;
#(
  parameter int CLK_DIV    = 100_000_000,
  parameter int PHYS_DIV   = 1_666_666,
  parameter int COUNT_SECS = 3,
  parameter int LAPS       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  race_controller_if.slave  bus
);

  localparam logic [2:0] COUNT_START = 3'(COUNT_SECS);
  localparam logic [3:0] LAP_MAX     = 4'(LAPS);
  localparam logic [9:0] TIME_MAX    = '1;

  state_e     state_q, state_d;
  logic [2:0] countdown_q, countdown_d;
  logic [3:0] lap_q, lap_d;
  logic [9:0] time_q, time_d;
  logic       phys_q, phys_d;
  logic       finish_q, finish_d;

  logic sec_en, sec_clr, sec_tick;
  logic phys_en, phys_clr, phys_wrap;

  tick_divider #(.DIV(CLK_DIV)) u_sec_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sec_en),
    .clr   (sec_clr),
    .tick  (sec_tick)
  );

  tick_divider #(.DIV(PHYS_DIV)) u_phys_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (phys_en),
    .clr   (phys_clr),
    .tick  (phys_wrap)
  );

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    lap_d       = lap_q;
    time_d      = time_q;
    finish_d    = 1'b0;
    sec_en      = 1'b0;
    sec_clr     = 1'b1;
    phys_en     = 1'b0;
    phys_clr    = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.start_p) begin
          state_d = SETTING;
          lap_d   = '0;
          time_d  = '0;
        end
      end
      SETTING: begin
        if (bus.confirm_p) begin
          state_d     = COUNTDOWN;
          countdown_d = COUNT_START;
        end else if (bus.start_p) begin
          state_d = IDLE;
        end
      end
      COUNTDOWN: begin
        sec_en  = 1'b1;
        sec_clr = 1'b0;
        if (sec_tick) begin
          if (countdown_q == 3'd1) begin
            state_d     = RACING;
            countdown_d = '0;
            sec_clr     = 1'b1;
          end else begin
            countdown_d = countdown_q - 3'd1;
          end
        end
      end
      RACING: begin
        sec_en   = 1'b1;
        sec_clr  = 1'b0;
        phys_en  = 1'b1;
        phys_clr = 1'b0;
        if (sec_tick && time_q != TIME_MAX) begin
          time_d = time_q + 10'd1;
        end
        // The final lap wins over a simultaneous pause; any other lap is counted and the pause still taken.
        if (bus.lap_cross_p && (lap_q + 4'd1 == LAP_MAX)) begin
          lap_d    = lap_q + 4'd1;
          state_d  = FINISH;
          finish_d = 1'b1;
        end else begin
          if (bus.lap_cross_p) begin
            lap_d = lap_q + 4'd1;
          end
          if (bus.pause_p) begin
            state_d = PAUSE;
          end
        end
      end
      PAUSE: begin
        // Both prescalers hold their count so the resumed second is not shortened.
        sec_clr  = 1'b0;
        phys_clr = 1'b0;
        if (bus.pause_p) begin
          state_d = RACING;
        end else if (bus.start_p) begin
          state_d = IDLE;
        end
      end
      FINISH: begin
        if (bus.start_p) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    phys_d = phys_wrap && (state_q == RACING) && (state_d == RACING);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      countdown_q <= '0;
      lap_q       <= '0;
      time_q      <= '0;
      phys_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      lap_q       <= lap_d;
      time_q      <= time_d;
      phys_q      <= phys_d;
      finish_q    <= finish_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.countdown = countdown_q;
  assign bus.lap_count = lap_q;
  assign bus.race_time = time_q;
  assign bus.phys_tick = phys_q;
  assign bus.finish_p  = finish_q;

endmodule

// File: tb/tb_race_controller.sv
// Scenario bench for race_controller with small dividers (CLK_DIV=10, PHYS_DIV=4, COUNT_SECS=3, LAPS=2).
module tb_race_controller;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] cd;
    logic [3:0] lap;
    logic [9:0] tm;
    logic       ph;
    logic       fin;
  } obs_t;

  logic clk;
  logic rst_n;
  race_controller_if bus();

  race_controller #(
    .CLK_DIV    (10),
    .PHYS_DIV   (4),
    .COUNT_SECS (3),
    .LAPS       (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t got;
  obs_t exp;

  function automatic obs_t mk(int st, int cd, int lap, int tm, int ph, int fin);
    obs_t o;
    o.st  = 3'(st);
    o.cd  = 3'(cd);
    o.lap = 4'(lap);
    o.tm  = 10'(tm);
    o.ph  = 1'(ph);
    o.fin = 1'(fin);
    return o;
  endfunction

  function automatic obs_t sample();
    return {bus.state, bus.countdown, bus.lap_count, bus.race_time, bus.phys_tick, bus.finish_p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic go_racing();
    do_reset();
    bus.start_p = 1'b1;   step(); bus.start_p = 1'b0;
    bus.confirm_p = 1'b1; step(); bus.confirm_p = 1'b0;
    repeat (30) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_p = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    step();
    bus.start_p = 1'b0;
    rst_n = 1'b1;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset: got %h expected %h", got, exp); end
  endtask

  task automatic test_countdown();
    do_reset();
    bus.start_p = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
    step();
    bus.start_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL idle_to_setting: got %h expected %h", got, exp); end

    bus.confirm_p = 1'b1;
    exp_q.push_back(mk(3, 3, 0, 0, 0, 0));
    exp_q.push_back(mk(3, 3, 0, 0, 0, 0));
    exp_q.push_back(mk(3, 2, 0, 0, 0, 0));
    exp_q.push_back(mk(3, 2, 0, 0, 0, 0));
    exp_q.push_back(mk(3, 1, 0, 0, 0, 0));
    exp_q.push_back(mk(3, 1, 0, 0, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 0, 0, 0));
    step();
    bus.confirm_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL setting_to_countdown: got %h expected %h", got, exp); end

    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 9 || k == 10 || k == 19 || k == 20 || k == 29 || k == 30) begin
        got = sample(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL countdown_at_%0d: got %h expected %h", k, got, exp); end
      end
    end
  endtask

  task automatic test_race_time();
    int   pulses = 0;
    int   wide = 0;
    logic prev = 1'b0;
    go_racing();
    exp_q.push_back(mk(4, 0, 0, 4, 1, 0));
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.phys_tick === 1'b1) pulses++;
      if (bus.phys_tick === 1'b1 && prev === 1'b1) wide++;
      prev = bus.phys_tick;
    end
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL race_40_cycles: got %h expected %h", got, exp); end
    checks++;
    if (pulses !== 10) begin errors++; $display("FAIL phys_pulse_count: got %0d expected 10", pulses); end
    checks++;
    if (wide !== 0) begin errors++; $display("FAIL phys_pulse_width: got %0d wide pulses expected 0", wide); end
  endtask

  task automatic test_pause();
    int bad = 0;
    go_racing();
    repeat (24) step();
    bus.pause_p = 1'b1;
    exp_q.push_back(mk(5, 0, 0, 2, 0, 0));
    step();
    bus.pause_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL pause_entry: got %h expected %h", got, exp); end

    repeat (50) begin
      step();
      if (bus.state !== 3'd5 || bus.race_time !== 10'd2 || bus.phys_tick !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL pause_hold: got %0d bad cycles expected 0", bad); end

    bus.pause_p = 1'b1;
    exp_q.push_back(mk(4, 0, 0, 2, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 2, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 3, 0, 0));
    step();
    bus.pause_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL resume: got %h expected %h", got, exp); end
    repeat (3) step();
    step();
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL resume_plus4: got %h expected %h", got, exp); end
    step();
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL resume_plus5: got %h expected %h", got, exp); end
  endtask

  task automatic test_laps();
    go_racing();
    bus.lap_cross_p = 1'b1;
    exp_q.push_back(mk(4, 0, 1, 0, 0, 0));
    step();
    bus.lap_cross_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL lap_one: got %h expected %h", got, exp); end
    step();

    bus.lap_cross_p = 1'b1;
    exp_q.push_back(mk(6, 0, 2, 0, 0, 1));
    exp_q.push_back(mk(6, 0, 2, 0, 0, 0));
    step();
    bus.lap_cross_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL lap_finish: got %h expected %h", got, exp); end
    step();
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL finish_pulse_width: got %h expected %h", got, exp); end

    bus.lap_cross_p = 1'b1;
    exp_q.push_back(mk(6, 0, 2, 0, 0, 0));
    step();
    bus.lap_cross_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL extra_lap: got %h expected %h", got, exp); end

    bus.start_p = 1'b1;
    exp_q.push_back(mk(0, 0, 2, 0, 0, 0));
    step();
    bus.start_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL finish_to_idle: got %h expected %h", got, exp); end
  endtask

  task automatic test_same_cycle();
    go_racing();
    bus.lap_cross_p = 1'b1; bus.pause_p = 1'b1;
    exp_q.push_back(mk(5, 0, 1, 0, 0, 0));
    step();
    bus.lap_cross_p = 1'b0; bus.pause_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL lap_and_pause: got %h expected %h", got, exp); end

    bus.pause_p = 1'b1;
    exp_q.push_back(mk(4, 0, 1, 0, 0, 0));
    step();
    bus.pause_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL unpause: got %h expected %h", got, exp); end

    bus.lap_cross_p = 1'b1; bus.pause_p = 1'b1;
    exp_q.push_back(mk(6, 0, 2, 0, 0, 1));
    step();
    bus.lap_cross_p = 1'b0; bus.pause_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL final_lap_beats_pause: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.start_p = 1'b1;   step(); bus.start_p = 1'b0;
    bus.confirm_p = 1'b1; step(); bus.confirm_p = 1'b0;
    repeat (13) step();
    rst_n = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    step();
    rst_n = 1'b1;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_mid_countdown: got %h expected %h", got, exp); end

    bus.start_p = 1'b1;   step(); bus.start_p = 1'b0;
    bus.confirm_p = 1'b1;
    exp_q.push_back(mk(3, 2, 0, 0, 0, 0));
    step();
    bus.confirm_p = 1'b0;
    repeat (10) step();
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL countdown_after_reset: got %h expected %h", got, exp); end
  endtask

  task automatic test_abort();
    go_racing();
    repeat (12) step();
    bus.pause_p = 1'b1;
    exp_q.push_back(mk(5, 0, 0, 1, 0, 0));
    step();
    bus.pause_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL abort_pause: got %h expected %h", got, exp); end

    bus.start_p = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
    step();
    bus.start_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL pause_to_idle: got %h expected %h", got, exp); end

    bus.start_p = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
    step();
    bus.start_p = 1'b0;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL setting_clears_time: got %h expected %h", got, exp); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    force dut.state_q = race_pkg::state_e'(3'd7);
    @(posedge clk);
    #1;
    release dut.state_q;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    step();
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL illegal_state: got %h expected %h", got, exp); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start_p = 1'b0;
    bus.confirm_p = 1'b0;
    bus.pause_p = 1'b0;
    bus.lap_cross_p = 1'b0;
    test_reset();
    test_countdown();
    test_race_time();
    test_pause();
    test_laps();
    test_same_cycle();
    test_reset_mid();
    test_abort();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
